cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Sequencer for the single-cycle register/ALU datapath core. Fetches fixed-format instructions over a request/acknowledge instruction-memory port. Decodes them and drives the core's control inputs: ALU select, write enable, register addresses, immediate data and the two data-source muxes. Provides start/halt control and a program counter with jumps, so the core can run small programs without an external host stepping it.

## Interface
- ADDR_W, 3, register-file address width (a1/a2)
- DATA_W, 8, datapath/immediate width
- PC_W, 8, program counter width; must be ≤ DATA_W
- INSTR_W, 4+2*ADDR_W+DATA_W (derived, not overridable), instruction width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin execution at PC 0; honoured only in IDLE or HALT
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_rdata  in  INSTR_W  fetched instruction, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- core_dout  in  DATA_W  core read-port value of register a1 (combinational)
- alu_sel  out  2  core ALU operation
- w_en  out  1  core register write enable
- a1  out  ADDR_W  destination / first source register
- a2  out  ADDR_W  second source register
- din  out  DATA_W  immediate to core
- din_sel  out  1  1: write din directly; 0: write ALU result
- d2_sel  out  1  1: ALU operand 2 = din; 0: register a2
- busy  out  1  high in FETCH or EXEC
- halted  out  1  high in HALT

## Operation
- Instruction fields (MSB→LSB): op[3:0], ra (ADDR_W), rb (ADDR_W), imm (DATA_W).
- Core semantics driven: reg[a1] ← din_sel ? din : ALU(reg[a1], d2_sel ? din : reg[a2]).
- FSM states:
  - IDLE: reset state. start → FETCH with PC=0.
  - FETCH: imem_req=1, imem_addr=PC, held until imem_ack. On the ack cycle IR ← imem_rdata, then → EXEC.
  - EXEC: exactly one cycle. Decode IR, drive core controls, update PC, then → FETCH. Exception: HALT → HALT.
  - HALT: start → FETCH with PC=0.
- Decode, in EXEC only; a1=ra, a2=rb, din=imm always in EXEC:
  - 0x0 NOP: no write. PC+1.
  - 0x1 LDI: w_en=1, din_sel=1. PC+1.
  - 0x4–0x7 ALU reg-reg: w_en=1, alu_sel=op[1:0], din_sel=0, d2_sel=0. PC+1.
  - 0x8–0xB ALU reg-imm: same as reg-reg but d2_sel=1.
  - 0xC JMP: PC ← imm[PC_W-1:0].
  - 0xD JZ: if core_dout==0, PC ← imm[PC_W-1:0]; else PC+1. No write.
  - 0xE JNZ: inverse of JZ.
  - 0xF HALT: no write, PC unchanged.
  - 0x2, 0x3: treated as NOP.
- PC arithmetic is modulo 2^PC_W: PC = 2^PC_W−1 increments to 0.
- Control outputs are combinational from state and IR. Outside EXEC: w_en=0, alu_sel=0, a1=a2=0, din=0, din_sel=0, d2_sel=0.

## Timing
- Reset (async assert): state=IDLE, PC=0, IR=0. All outputs 0; imem_req drops immediately, including mid-fetch. Deassertion is synchronised to clk by the instantiating level.
- Minimum instruction latency: 2 cycles (FETCH with same-cycle ack, then EXEC). Each wait cycle without ack adds 1.
- imem_req stays high and imem_addr stable from FETCH entry until the ack cycle inclusive. imem_ack outside FETCH is ignored.
- The register write occurs at the clk edge ending EXEC. The next fetch address is visible in the following FETCH cycle.
- start while busy=1 is ignored. start in the same cycle as HALT decode is ignored.
- JZ/JNZ sample core_dout during EXEC, i.e. the value of reg[ra] before any write that cycle (branches never write).
- busy and halted are never both 1.

## Test plan
- Reset mid-FETCH with imem_req=1: assert rst_n=0 → imem_req=0 and all outputs 0 without a clock edge; after release, state stays IDLE until start.
- Program LDI r1,5; ADDI(0x8) r1,3; HALT with 0-wait ack: 6 cycles from start to halted=1. Write-cycle controls: w_en=1,a1=1,din=5,din_sel=1, then w_en=1,d2_sel=1,din=3,alu_sel=0.
- Ack delayed 3 cycles: imem_req held 4 cycles with constant imem_addr; IR captured only on the ack cycle; no w_en during the wait.
- JZ with core_dout=0 and imm=0x20 → next imem_addr=0x20. With core_dout=7 → next imem_addr=PC+1. JNZ checked for both outcomes.
- PC wrap: JMP 0xFF then a NOP at 0xFF → next fetch at 0x00.
- start pulsed during EXEC → ignored. start in HALT → fetch from 0x00 next cycle, halted=0, busy=1.

Source files
------------

// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the register/ALU datapath core: fetches fixed-format
// instructions over a req/ack port, decodes them and drives the core controls.
module cpu_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            imem_req,
    output logic [PC_W-1:0]                 imem_addr,
    input  logic [4+2*ADDR_W+DATA_W-1:0]    imem_rdata,
    input  logic                            imem_ack,
    input  logic [DATA_W-1:0]               core_dout,
    output logic [1:0]                      alu_sel,
    output logic                            w_en,
    output logic [ADDR_W-1:0]               a1,
    output logic [ADDR_W-1:0]               a2,
    output logic [DATA_W-1:0]               din,
    output logic                            din_sel,
    output logic                            d2_sel,
    output logic                            busy,
    output logic                            halted
);

    localparam int INSTR_W = 4 + 2 * ADDR_W + DATA_W;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JNZ  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;

    // Instruction fields: op | ra | rb | imm
    logic [3:0]           op;
    logic [ADDR_W-1:0]    ra;
    logic [ADDR_W-1:0]    rb;
    logic [DATA_W-1:0]    imm;
    logic [PC_W-1:0]      jmp_tgt;
    logic [PC_W-1:0]      pc_inc;
    logic                 dout_zero;

    assign op        = ir_q[INSTR_W-1 -: 4];
    assign ra        = ir_q[INSTR_W-5 -: ADDR_W];
    assign rb        = ir_q[DATA_W+ADDR_W-1 -: ADDR_W];
    assign imm       = ir_q[DATA_W-1:0];
    assign jmp_tgt   = imm[PC_W-1:0];
    assign pc_inc    = pc_q + PC_W'(1);
    assign dout_zero = (core_dout == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, PC and IR
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_JMP:  pc_d = jmp_tgt;
                    OP_JZ:   pc_d = dout_zero ? jmp_tgt : pc_inc;
                    OP_JNZ:  pc_d = dout_zero ? pc_inc : jmp_tgt;
                    OP_HALT: begin
                        state_d = S_HALT;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;

    // Outputs: core controls are live only during EXEC
    always_comb begin
        imem_req = (state_q == S_FETCH);
        busy     = (state_q == S_FETCH) || (state_q == S_EXEC);
        halted   = (state_q == S_HALT);
        w_en     = 1'b0;
        alu_sel  = 2'b00;
        a1       = '0;
        a2       = '0;
        din      = '0;
        din_sel  = 1'b0;
        d2_sel   = 1'b0;
        if (state_q == S_EXEC) begin
            a1  = ra;
            a2  = rb;
            din = imm;
            if (op == OP_LDI) begin
                w_en    = 1'b1;
                din_sel = 1'b1;
            end else if (op[3:2] == 2'b01 || op[3:2] == 2'b10) begin
                // 0x4-0x7 reg-reg, 0x8-0xB reg-imm
                w_en    = 1'b1;
                alu_sel = op[1:0];
                d2_sel  = op[3];
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: table of single-instruction vectors plus
// hand-written sequences for reset, wait states, program timing and restart.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [17:0] imem_rdata;
    logic        imem_ack;
    logic [7:0]  core_dout = 8'h00;
    logic [1:0]  alu_sel;
    logic        w_en;
    logic [2:0]  a1, a2;
    logic [7:0]  din;
    logic        din_sel, d2_sel, busy, halted;

    logic [17:0] prog [256];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    always #5 clk = ~clk;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .core_dout(core_dout), .alu_sel(alu_sel),
        .w_en(w_en), .a1(a1), .a2(a2), .din(din), .din_sel(din_sel),
        .d2_sel(d2_sel), .busy(busy), .halted(halted)
    );

    // Instruction memory model with programmable wait states
    assign imem_rdata = prog[imem_addr];
    assign imem_ack   = imem_req && (wait_cnt == ack_delay);
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    typedef struct {
        logic [3:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic [7:0] dout;
        logic       start_in_exec;
        logic [7:0] pc;
        logic       w;
        logic [1:0] alu;
        logic       ds;
        logic       d2;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] ra,
                                       input logic [2:0] rb, input logic [7:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic vec_t mkv(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                 input logic [7:0] imm, input logic [7:0] dout, input logic st,
                                 input logic [7:0] pc, input logic w, input logic [1:0] alu,
                                 input logic ds, input logic d2);
        vec_t v;
        v.op = op; v.ra = ra; v.rb = rb; v.imm = imm; v.dout = dout;
        v.start_in_exec = st; v.pc = pc; v.w = w; v.alu = alu; v.ds = ds; v.d2 = d2;
        return v;
    endfunction

    function automatic logic [18:0] ctrl_pack(input logic w, input logic [1:0] alu,
                                              input logic [2:0] x1, input logic [2:0] x2,
                                              input logic [7:0] d, input logic ds, input logic d2);
        return {w, alu, x1, x2, d, ds, d2};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else             pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
    endtask

    logic [18:0] all_outs;
    assign all_outs = {imem_req, w_en, alu_sel, a1, a2, din, din_sel, d2_sel, busy, halted};

    initial begin
        int cycles;
        int wcnt;
        logic [18:0] exp_w [2];

        for (int i = 0; i < 256; i++) prog[i] = mk(4'h0, 3'd0, 3'd0, 8'h00);

        //              op     ra    rb    imm    dout   st    pc     w     alu   ds    d2
        vecs[0]  = mkv(4'h0, 3'd2, 3'd3, 8'h11, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mkv(4'h1, 3'd1, 3'd0, 8'h05, 8'h00, 1'b0, 8'h01, 1'b1, 2'd0, 1'b1, 1'b0);
        vecs[2]  = mkv(4'h2, 3'd4, 3'd5, 8'h33, 8'h00, 1'b0, 8'h02, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[3]  = mkv(4'h6, 3'd1, 3'd2, 8'h00, 8'h00, 1'b1, 8'h03, 1'b1, 2'd2, 1'b0, 1'b0);
        vecs[4]  = mkv(4'hB, 3'd7, 3'd0, 8'h80, 8'h00, 1'b0, 8'h04, 1'b1, 2'd3, 1'b0, 1'b1);
        vecs[5]  = mkv(4'hC, 3'd0, 3'd0, 8'h20, 8'h00, 1'b0, 8'h05, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[6]  = mkv(4'hD, 3'd3, 3'd0, 8'h40, 8'h00, 1'b0, 8'h20, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[7]  = mkv(4'hD, 3'd3, 3'd0, 8'h50, 8'h07, 1'b0, 8'h40, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[8]  = mkv(4'hE, 3'd2, 3'd0, 8'h10, 8'h07, 1'b0, 8'h41, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[9]  = mkv(4'hE, 3'd2, 3'd0, 8'h60, 8'h00, 1'b0, 8'h10, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[10] = mkv(4'hC, 3'd0, 3'd0, 8'hFF, 8'h00, 1'b0, 8'h11, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[11] = mkv(4'h0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[12] = mkv(4'hF, 3'd1, 3'd0, 8'h99, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);

        // Reset state
        #2;
        chk("reset_outputs", 32'(all_outs), 32'h0);
        chk("reset_addr", 32'(imem_addr), 32'h0);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_no_start", 32'({busy, halted, imem_req}), 32'h0);

        // Table: one instruction per vector, placed at its expected fetch address
        prog[0] = mk(vecs[0].op, vecs[0].ra, vecs[0].rb, vecs[0].imm);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            prog[vecs[i].pc] = mk(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].imm);
            core_dout = vecs[i].dout;
            chk($sformatf("v%0d_fetch", i), 32'({imem_req, busy, imem_addr}),
                32'({1'b1, 1'b1, vecs[i].pc}));
            step();
            start = vecs[i].start_in_exec;
            chk($sformatf("v%0d_exec", i),
                32'(ctrl_pack(w_en, alu_sel, a1, a2, din, din_sel, d2_sel)),
                32'(ctrl_pack(vecs[i].w, vecs[i].alu, vecs[i].ra, vecs[i].rb,
                              vecs[i].imm, vecs[i].ds, vecs[i].d2)));
            $display("vec %0d pc=%02h op=%h dout=%02h w_en=%0d alu=%0d",
                     i, vecs[i].pc, vecs[i].op, vecs[i].dout, w_en, alu_sel);
            step();
            start = 1'b0;
        end
        chk("halt_state", 32'({halted, busy, imem_req}), 32'b100);
        step();
        chk("halt_stays", 32'({halted, busy}), 32'b10);

        // Restart from HALT: fetch from 0x00 in the next cycle
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_fetch", 32'({halted, busy, imem_req, imem_addr}), 32'({3'b011, 8'h00}));

        // LDI r1,5 ; ADDI r1,3 ; HALT with zero-wait ack
        do_reset();
        prog[0] = mk(4'h1, 3'd1, 3'd0, 8'd5);
        prog[1] = mk(4'h8, 3'd1, 3'd0, 8'd3);
        prog[2] = mk(4'hF, 3'd0, 3'd0, 8'd0);
        exp_w[0] = ctrl_pack(1'b1, 2'd0, 3'd1, 3'd0, 8'd5, 1'b1, 1'b0);
        exp_w[1] = ctrl_pack(1'b1, 2'd0, 3'd1, 3'd0, 8'd3, 1'b0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        cycles = 0;
        wcnt = 0;
        while (!halted && cycles < 20) begin
            if (w_en) begin
                if (wcnt < 2)
                    chk($sformatf("prog_write%0d", wcnt),
                        32'(ctrl_pack(w_en, alu_sel, a1, a2, din, din_sel, d2_sel)),
                        32'(exp_w[wcnt]));
                wcnt++;
            end
            step();
            cycles++;
        end
        $display("program halted after %0d cycles, %0d writes", cycles, wcnt);
        chk("prog_cycles", 32'(cycles), 32'd6);
        chk("prog_writes", 32'(wcnt), 32'd2);

        // Three wait cycles: IR must be taken only on the ack cycle
        do_reset();
        ack_delay = 3;
        prog[0] = mk(4'hF, 3'd0, 3'd0, 8'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) prog[0] = mk(4'h1, 3'd2, 3'd0, 8'h09);
            chk($sformatf("wait%0d_req", c), 32'({imem_req, imem_ack, w_en, imem_addr}),
                32'({1'b1, (c == 3), 1'b0, 8'h00}));
            step();
        end
        chk("wait_exec_ldi", 32'(ctrl_pack(w_en, alu_sel, a1, a2, din, din_sel, d2_sel)),
            32'(ctrl_pack(1'b1, 2'd0, 3'd2, 3'd0, 8'h09, 1'b1, 1'b0)));
        step();
        chk("wait_next_fetch", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h01}));

        // Asynchronous reset in the middle of a fetch
        ack_delay = 5;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'(all_outs), 32'h0);
        chk("async_reset_addr", 32'(imem_addr), 32'h0);
        #3;
        rst_n = 1'b1;
        ack_delay = 0;
        for (int c = 0; c < 3; c++) step();
        chk("post_reset_idle", 32'({busy, halted, imem_req}), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
